life_game_stepper: RTL and testbench
====================================

LIFE_GAME_STEPPER -- requirements
Module: life_game_stepper

Interface
REQ-001 Parameter ROWS, default 48, number of world rows; each row is 64 cells held in 2 words.
REQ-002 Parameter INDEX_ADDR, default 7'b1111111, cell-bus address of the device's world-index register.
REQ-003 clock  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  request one generation step; sampled only while busy=0.
REQ-006 cell_data_in  input  32  current-world word returned combinationally for cell_address in the same cycle.
REQ-007 cell_write  output  1  write strobe to the display device's cell bus.
REQ-008 cell_address  output  7  word address {row[5:0], half}; bit x of word {y,h} is column h*32+x.
REQ-009 cell_data_out  output  32  write data to the device.
REQ-010 busy  output  1  high while a step is in progress.
REQ-011 done  output  1  one-cycle pulse when a step completes.
REQ-012 All outputs SHALL be driven from registers or state decode only, with no combinational path from any input.

Function
REQ-013 States: IDLE, PRIME, WRITE0, WRITE1, FETCH0, FETCH1, SWAP.
REQ-014 IDLE: busy=0, cell_write=0; start=1 enters PRIME with row counter y=0.
REQ-015 PRIME SHALL take 6 read cycles in this order: row ROWS-1 h0 and h1, then row 0 h0 and h1, then row 1 h0 and h1. Each word is captured into the 3x64-bit window (above/cur/below) at the end of its cycle.
REQ-016 Next state per cell (B3/S23): alive if the neighbour count is 3, or if the count is 2 and the cell is alive. Neighbours are the 8 surrounding cells.
REQ-017 The world is toroidal. Column neighbours wrap mod 64; word-half boundaries (bit31/bit32) are ordinary neighbours. Row neighbours wrap mod ROWS.
REQ-018 All 64 next-state bits SHALL be computed combinationally from the window; neighbour counts are 4-bit.
REQ-019 WRITE0 drives cell_write=1, cell_address={y,0}, cell_data_out=next[31:0]. WRITE1 drives the same with {y,1} and next[63:32].
REQ-020 After WRITE1: if y==ROWS-1, go to SWAP.
REQ-021 After WRITE1 with y<ROWS-1: go to FETCH0/FETCH1, which read row (y+2) mod ROWS h0 then h1. At the end of FETCH1 the window shifts (above<=cur, cur<=below, below<=fetched row) and y increments, then return to WRITE0.
REQ-022 Reads always hit the current world and writes always hit the other buffer, so row 0 re-read at wrap holds the original generation.
REQ-023 SWAP drives cell_write=1, cell_address=INDEX_ADDR, cell_data_out={31'b0, ~frame_index}. frame_index toggles at the end of the cycle, then the block returns to IDLE.
REQ-024 done=1 in the first IDLE cycle after SWAP only.
REQ-025 busy SHALL be high for exactly 6+4*ROWS-2+1 cycles per step (197 at ROWS=48).
REQ-026 start while busy=1 is ignored, not queued. start held high in the done cycle begins a new step immediately.
REQ-027 cell_data_out=0 whenever cell_write=0. cell_address holds the read address in PRIME/FETCH states and is 0 in IDLE.

Reset
REQ-028 While reset is high the block SHALL hold IDLE with window=0, y=0, frame_index=0 (matches the device power-up index), and cell_write=0, cell_address=0, cell_data_out=0, busy=0, done=0.
REQ-029 Reset mid-step SHALL abort immediately with no further writes and no SWAP write. The partially written buffer is discarded; the device index is unchanged.

Verification
REQ-030 Glider: current world addr0=0x2, addr2=0x4, addr4=0x7, all else 0; pulse start -> writes addr2=0x5, addr4=0x6, addr6=0x2, all other rows 0; SWAP writes addr 127 data 0x1; done on cycle 198 after the start edge.
REQ-031 Wrap: row 10 columns 63,0,1 live (addr20=0x3, addr21=0x80000000) -> next world addr18=addr20=addr22=0x1, addr21=0; all else 0.
REQ-032 Row wrap: block at rows 47/0, columns 5-6 (addr94=addr0=0x60) -> identical words rewritten; second step SWAP data 0x0.
REQ-033 start pulsed again at cycle 50 of a step -> no effect; exactly 96 data writes plus 1 index write; single done.
REQ-034 Reset asserted on cycle 100 of a step -> cell_write low in the same cycle, busy=0, no write to addr 127; the next step's SWAP writes data 0x1.
REQ-035 Empty world -> all 96 writes carry 0x0; cell_data_out=0 on every non-write cycle.

Source files
------------

// File: rtl/life_game_stepper_if.sv
// Cell-bus and step-control bundle between the life stepper and its display device.
// Latency: none, wires only. Backpressure: none; the device answers reads in the same cycle.
// Ports: start/busy/done step control; cell_write/cell_address/cell_data_out/cell_data_in cell bus.
interface life_game_stepper_if;
  logic        start;
  logic        busy;
  logic        done;
  logic        cell_write;
  logic [6:0]  cell_address;
  logic [31:0] cell_data_out;
  logic [31:0] cell_data_in;

  // master: the stepper; slave: the display device / host side.
  modport master (
    input  start, cell_data_in,
    output busy, done, cell_write, cell_address, cell_data_out
  );
  modport slave (
    output start, cell_data_in,
    input  busy, done, cell_write, cell_address, cell_data_out
  );
endinterface

// File: rtl/life_game_stepper.sv
// Computes one B3/S23 generation of a toroidal 64 x ROWS world, reading the current buffer and writing the other.
// Latency: busy for 6 + 4*ROWS - 1 cycles per step; done pulses in the first idle cycle afterwards.
// Backpressure: none; start is ignored while busy, reads are answered combinationally by the device.
// Ports: clock, reset (async, active-high); bus (master modport): start, busy, done, cell_write,
//        cell_address {row,half}, cell_data_out, cell_data_in.
module life_game_stepper #(
  parameter int         ROWS       = 48,
  parameter logic [6:0] INDEX_ADDR = 7'b1111111
) (
  input logic                  clock,
  input logic                  reset,
  life_game_stepper_if.master  bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PRIME  = 3'd1,
    WRITE0 = 3'd2,
    WRITE1 = 3'd3,
    FETCH0 = 3'd4,
    FETCH1 = 3'd5,
    SWAP   = 3'd6
  } state_t;

  localparam logic [5:0] LAST_ROW = 6'(ROWS - 1);

  state_t      state, state_nxt;
  logic [5:0]  y;
  logic [2:0]  prime_cnt;
  logic [63:0] above, cur, below;
  logic [31:0] fetch_lo;
  logic        frame_index;
  logic        done_q;
  logic [63:0] next_row;

  // Row fetched ahead of the window: (y + 2) mod ROWS.
  logic [6:0]  y_plus2;
  logic [5:0]  fetch_row;
  assign y_plus2   = {1'b0, y} + 7'd2;
  assign fetch_row = (y_plus2 >= 7'(ROWS)) ? 6'(y_plus2 - 7'(ROWS)) : y_plus2[5:0];

  // Priming reads rows ROWS-1, 0, 1 (two halves each) so the window starts centred on row 0.
  logic [5:0]  prime_row;
  always_comb begin
    prime_row = 6'd1;
    case (prime_cnt[2:1])
      2'd0:    prime_row = LAST_ROW;
      2'd1:    prime_row = 6'd0;
      default: prime_row = 6'd1;
    endcase
  end

  // Column rotations: *_l[c] holds column c-1, *_r[c] holds column c+1, both mod 64.
  logic [63:0] above_l, above_r, cur_l, cur_r, below_l, below_r;
  assign above_l = {above[62:0], above[63]};
  assign above_r = {above[0], above[63:1]};
  assign cur_l   = {cur[62:0], cur[63]};
  assign cur_r   = {cur[0], cur[63:1]};
  assign below_l = {below[62:0], below[63]};
  assign below_r = {below[0], below[63:1]};

  always_comb begin
    logic [3:0] cnt;
    next_row = '0;
    cnt      = '0;
    for (int c = 0; c < 64; c++) begin
      cnt = {3'b0, above_l[c]} + {3'b0, above[c]} + {3'b0, above_r[c]}
          + {3'b0, cur_l[c]}                      + {3'b0, cur_r[c]}
          + {3'b0, below_l[c]} + {3'b0, below[c]} + {3'b0, below_r[c]};
      next_row[c] = (cnt == 4'd3) || ((cnt == 4'd2) && cur[c]);
    end
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = PRIME;
      PRIME:   if (prime_cnt == 3'd5) state_nxt = WRITE0;
      WRITE0:  state_nxt = WRITE1;
      WRITE1:  state_nxt = (y == LAST_ROW) ? SWAP : FETCH0;
      FETCH0:  state_nxt = FETCH1;
      FETCH1:  state_nxt = WRITE0;
      SWAP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decode from state and registers only; nothing here depends on an input.
  always_comb begin
    bus.cell_write    = 1'b0;
    bus.cell_address  = 7'd0;
    bus.cell_data_out = 32'd0;
    bus.busy          = 1'b1;
    case (state)
      IDLE:   bus.busy = 1'b0;
      PRIME:  bus.cell_address = {prime_row, prime_cnt[0]};
      WRITE0: begin
        bus.cell_write    = 1'b1;
        bus.cell_address  = {y, 1'b0};
        bus.cell_data_out = next_row[31:0];
      end
      WRITE1: begin
        bus.cell_write    = 1'b1;
        bus.cell_address  = {y, 1'b1};
        bus.cell_data_out = next_row[63:32];
      end
      FETCH0: bus.cell_address = {fetch_row, 1'b0};
      FETCH1: bus.cell_address = {fetch_row, 1'b1};
      SWAP: begin
        bus.cell_write    = 1'b1;
        bus.cell_address  = INDEX_ADDR;
        bus.cell_data_out = {31'b0, ~frame_index};
      end
      default: bus.busy = 1'b0;
    endcase
  end

  assign bus.done = done_q;

  // Window, row counter and frame index.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      above       <= '0;
      cur         <= '0;
      below       <= '0;
      fetch_lo    <= '0;
      y           <= '0;
      prime_cnt   <= '0;
      frame_index <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= (state == SWAP);
      case (state)
        IDLE: begin
          y         <= '0;
          prime_cnt <= '0;
        end
        PRIME: begin
          prime_cnt <= prime_cnt + 3'd1;
          case (prime_cnt)
            3'd0:    above[31:0]  <= bus.cell_data_in;
            3'd1:    above[63:32] <= bus.cell_data_in;
            3'd2:    cur[31:0]    <= bus.cell_data_in;
            3'd3:    cur[63:32]   <= bus.cell_data_in;
            3'd4:    below[31:0]  <= bus.cell_data_in;
            default: below[63:32] <= bus.cell_data_in;
          endcase
        end
        FETCH0: fetch_lo <= bus.cell_data_in;
        FETCH1: begin
          above <= cur;
          cur   <= below;
          below <= {bus.cell_data_in, fetch_lo};
          y     <= y + 6'd1;
        end
        SWAP:   frame_index <= ~frame_index;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_life_game_stepper.sv
// Scoreboarded bench for life_game_stepper with a double-buffered display-device model.
// Latency: checks done timing and busy length per step. Backpressure: none on the cell bus.
// Ports: none; instantiates the interface, the stepper and a behavioural device.
module tb_life_game_stepper;
  localparam int         ROWS = 48;
  localparam logic [6:0] IDX  = 7'h7f;

  typedef struct packed {
    logic [6:0]  addr;
    logic [31:0] data;
  } wr_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  life_game_stepper_if bus();

  life_game_stepper #(.ROWS(ROWS), .INDEX_ADDR(IDX)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.master)
  );

  always #5 clock = ~clock;

  // Display device: reads come from the shown buffer, data writes land in the hidden one.
  logic [31:0] mem0 [128];
  logic [31:0] mem1 [128];
  logic        dev_idx = 1'b0;

  assign bus.cell_data_in = dev_idx ? mem1[bus.cell_address] : mem0[bus.cell_address];

  always @(posedge clock) begin
    if (bus.cell_write) begin
      if (bus.cell_address == IDX) dev_idx <= bus.cell_data_out[0];
      else if (dev_idx)            mem0[bus.cell_address] <= bus.cell_data_out;
      else                         mem1[bus.cell_address] <= bus.cell_data_out;
    end
  end

  int          n_cmp    = 0;
  int          n_bad    = 0;
  int          n_writes = 0;
  wr_t         sb [$];
  wr_t         mon_e;
  logic [31:0] exp_img [96];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every write is matched against the scoreboard; non-write cycles must drive zero data.
  always @(negedge clock) begin
    if (bus.cell_write) begin
      n_writes++;
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_write: got addr %0d data 0x%0h expected no write",
                 bus.cell_address, bus.cell_data_out);
      end else begin
        mon_e = sb.pop_front();
        check("write_addr", 32'(bus.cell_address), 32'(mon_e.addr));
        check("write_data", bus.cell_data_out, mon_e.data);
      end
    end else begin
      check("idle_data_zero", bus.cell_data_out, 32'd0);
    end
  end

  task automatic clear_world();
    for (int a = 0; a < 128; a++) begin
      mem0[a] = 32'd0;
      mem1[a] = 32'd0;
    end
  endtask

  task automatic set_word(input int a, input logic [31:0] d);
    if (dev_idx) mem1[a] = d;
    else         mem0[a] = d;
  endtask

  task automatic clear_exp();
    for (int a = 0; a < 96; a++) exp_img[a] = 32'd0;
  endtask

  task automatic push_step(input logic [31:0] swap_data);
    wr_t e;
    for (int a = 0; a < 96; a++) begin
      e.addr = 7'(a);
      e.data = exp_img[a];
      sb.push_back(e);
    end
    e.addr = IDX;
    e.data = swap_data;
    sb.push_back(e);
  endtask

  // Sample k is taken 1ns after the k-th edge following the start edge (k=0 is the start edge).
  task automatic run_step(input int restart_at, input int reset_at,
                          output int done_at, output int busy_n);
    done_at = -1;
    busy_n  = 0;
    @(negedge clock);
    bus.start = 1'b1;
    @(posedge clock);
    #1 bus.start = 1'b0;
    for (int k = 0; k < 400; k++) begin
      if (k > 0) begin
        @(posedge clock);
        #1;
      end
      if (bus.busy) busy_n++;
      if (bus.done) begin
        done_at = k;
        break;
      end
      bus.start = (k == restart_at);
      if (k == reset_at) begin
        reset = 1'b1;
        #1;
        check("reset_write_low", 32'(bus.cell_write), 32'd0);
        check("reset_busy_low", 32'(bus.busy), 32'd0);
        sb.delete();
        @(posedge clock);
        #1;
        check("reset_hold_busy", 32'(bus.busy), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        break;
      end
    end
  endtask

  // Finishes a normal step: done at sample 197 (the 198th cycle the start edge opens),
  // 197 busy cycles, one-cycle done pulse, all expected writes consumed.
  task automatic finish_step(input string name, input int done_at, input int busy_n);
    check({name, "_done_cycle"}, 32'(done_at), 32'd197);
    check({name, "_busy_cycles"}, 32'(busy_n), 32'd197);
    @(posedge clock);
    #1;
    check({name, "_done_pulse"}, 32'(bus.done), 32'd0);
    check({name, "_sb_empty"}, 32'(sb.size()), 32'd0);
  endtask

  int done_at, busy_n, w0;

  initial begin
    bus.start = 1'b0;
    clear_world();
    clear_exp();

    // Reset state.
    repeat (3) @(posedge clock);
    #1;
    check("rst_cell_write", 32'(bus.cell_write), 32'd0);
    check("rst_cell_address", 32'(bus.cell_address), 32'd0);
    check("rst_cell_data_out", bus.cell_data_out, 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    repeat (2) @(posedge clock);

    // Glider, one step.
    set_word(0, 32'h2); set_word(2, 32'h4); set_word(4, 32'h7);
    clear_exp();
    exp_img[2] = 32'h5; exp_img[4] = 32'h6; exp_img[6] = 32'h2;
    push_step(32'h1);
    run_step(-1, -1, done_at, busy_n);
    finish_step("glider", done_at, busy_n);

    // Reset mid-step (sample 99, a WRITE1 cycle) on glider generation 1.
    clear_exp();
    exp_img[2] = 32'h4; exp_img[4] = 32'h5; exp_img[6] = 32'h6;
    push_step(32'h0);
    w0 = n_writes;
    run_step(-1, 99, done_at, busy_n);
    check("abort_no_done", 32'(done_at), 32'hffff_ffff);
    repeat (3) @(posedge clock);
    #1;
    check("abort_idle_busy", 32'(bus.busy), 32'd0);
    check("abort_write_count", 32'(n_writes - w0), 32'd47);
    check("abort_dev_idx", 32'(dev_idx), 32'd1);

    // Block straddling the row wrap, two steps; frame index was cleared by the reset.
    clear_world();
    set_word(94, 32'h60); set_word(0, 32'h60);
    clear_exp();
    exp_img[94] = 32'h60; exp_img[0] = 32'h60;
    push_step(32'h1);
    run_step(-1, -1, done_at, busy_n);
    finish_step("block1", done_at, busy_n);
    push_step(32'h0);
    run_step(-1, -1, done_at, busy_n);
    finish_step("block2", done_at, busy_n);

    // Start re-pulsed at sample 49 of a step is ignored.
    clear_world();
    set_word(94, 32'h60); set_word(0, 32'h60);
    push_step(32'h1);
    w0 = n_writes;
    run_step(49, -1, done_at, busy_n);
    finish_step("restart", done_at, busy_n);
    check("restart_write_count", 32'(n_writes - w0), 32'd97);
    repeat (3) @(posedge clock);
    #1;
    check("restart_not_queued", 32'(bus.busy), 32'd0);

    // Horizontal blinker across the column wrap on row 10.
    clear_world();
    set_word(20, 32'h3); set_word(21, 32'h8000_0000);
    clear_exp();
    exp_img[18] = 32'h1; exp_img[20] = 32'h1; exp_img[22] = 32'h1;
    push_step(32'h0);
    run_step(-1, -1, done_at, busy_n);
    finish_step("wrap", done_at, busy_n);

    // Empty world.
    clear_world();
    clear_exp();
    push_step(32'h1);
    run_step(-1, -1, done_at, busy_n);
    finish_step("empty", done_at, busy_n);

    repeat (2) @(posedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
